// File: rtl/bp_be_dcache_wbuf_ctrl.sv
// Control for the 2-entry data-cache write buffer: tracks occupancy, steers the
// queue's enables/muxes, snoops load addresses and flags protocol misuse.
module bp_be_dcache_wbuf_ctrl #(
  parameter int addr_width_p = 40
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    v_i,
  output logic                    ready_o,
  output logic                    v_o,
  input  logic                    yumi_i,
  output logic                    el0_en_o,
  output logic                    el1_en_o,
  output logic                    mux0_sel_o,
  output logic                    mux1_sel_o,
  input  logic [addr_width_p-1:0] el0_addr_i,
  input  logic [addr_width_p-1:0] el1_addr_i,
  input  logic [addr_width_p-1:0] lookup_addr_i,
  output logic                    el0_hit_o,
  output logic                    el1_hit_o,
  output logic                    empty_o,
  output logic                    full_o,
  output logic                    err_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e state, state_nxt;
  logic   err_r, err_nxt;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= ST_EMPTY;
      err_r <= 1'b0;
    end else begin
      state <= state_nxt;
      err_r <= err_nxt;
    end
  end

  // Enables are gated by reset so a pending v_i cannot load the queue while held in reset.
  always_comb begin
    state_nxt  = state;
    err_nxt    = err_r;
    el0_en_o   = 1'b0;
    el1_en_o   = 1'b0;
    mux0_sel_o = 1'b0;
    if (reset_n_i) begin
      unique case (state)
        ST_EMPTY: begin
          if (v_i) begin
            el1_en_o  = 1'b1;
            state_nxt = ST_ONE;
          end
          if (yumi_i) err_nxt = 1'b1;
        end
        ST_ONE: begin
          if (v_i && !yumi_i) begin
            el0_en_o  = 1'b1;
            state_nxt = ST_FULL;
          end else if (v_i && yumi_i) begin
            el1_en_o  = 1'b1;
          end else if (yumi_i) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // Shift el0 into the head; a same-cycle push refills el0 even though ready_o=0.
          if (yumi_i) begin
            el1_en_o   = 1'b1;
            mux0_sel_o = 1'b1;
            el0_en_o   = v_i;
            if (!v_i) state_nxt = ST_ONE;
          end else if (v_i) begin
            err_nxt = 1'b1;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  assign v_o        = (state != ST_EMPTY);
  assign ready_o    = (state != ST_FULL);
  assign empty_o    = (state == ST_EMPTY);
  assign full_o     = (state == ST_FULL);
  assign mux1_sel_o = (state != ST_EMPTY);
  assign err_o      = err_r;

  assign el1_hit_o  = (state != ST_EMPTY) && (el1_addr_i == lookup_addr_i);
  assign el0_hit_o  = (state == ST_FULL)  && (el0_addr_i == lookup_addr_i);

endmodule

// File: tb/tb_bp_be_dcache_wbuf_ctrl.sv
// Bench for bp_be_dcache_wbuf_ctrl: a behavioural FIFO model predicts outputs and
// the contents of an attached 2-entry queue driven by the controller's enables.
module tb_bp_be_dcache_wbuf_ctrl;

  localparam int AW = 40;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          v_in, yumi_in;
  logic [AW-1:0] data_in, lookup;
  logic          ready, v_out, el0_en, el1_en, mux0_sel, mux1_sel;
  logic          el0_hit, el1_hit, empty, full, err;
  logic [AW-1:0] el0_q, el1_q;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] q[$];
  logic          m_err;

  typedef struct packed {
    logic          v;
    logic          y;
    logic [AW-1:0] d;
    logic [AW-1:0] l;
  } step_t;

  localparam logic [AW-1:0] A = 40'h80;
  localparam logic [AW-1:0] B = 40'h12_3456_7890;
  localparam logic [AW-1:0] C = 40'hAB_CDEF_0011;

  bp_be_dcache_wbuf_ctrl #(.addr_width_p(AW)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v_in), .ready_o(ready), .v_o(v_out),
    .yumi_i(yumi_in), .el0_en_o(el0_en), .el1_en_o(el1_en), .mux0_sel_o(mux0_sel),
    .mux1_sel_o(mux1_sel), .el0_addr_i(el0_q), .el1_addr_i(el1_q),
    .lookup_addr_i(lookup), .el0_hit_o(el0_hit), .el1_hit_o(el1_hit),
    .empty_o(empty), .full_o(full), .err_o(err)
  );

  always #5 clk = ~clk;

  // The 2-entry wbuf queue the controller steers: el1 is the head.
  always @(posedge clk) begin
    if (el1_en) el1_q <= mux0_sel ? el0_q : data_in;
    if (el0_en) el0_q <= data_in;
  end

  wire [10:0] obs = {v_out, ready, empty, full, mux1_sel, el1_en, el0_en, mux0_sel,
                     el1_hit, el0_hit, err};

  function automatic logic [10:0] exp_outs();
    int   n = q.size();
    logic e1 = 1'b0, e0 = 1'b0, m0 = 1'b0, h1 = 1'b0, h0 = 1'b0;
    if (!reset_n) return 11'b01100000000;
    if (n == 0 && v_in) e1 = 1'b1;
    if (n == 1 && v_in) begin
      if (yumi_in) e1 = 1'b1;
      else e0 = 1'b1;
    end
    if (n == 2 && yumi_in) begin
      e1 = 1'b1; m0 = 1'b1; e0 = v_in;
    end
    if (n >= 1) h1 = (q[0] == lookup);
    if (n == 2) h0 = (q[1] == lookup);
    return {n != 0, n != 2, n == 0, n == 2, n != 0, e1, e0, m0, h1, h0, m_err};
  endfunction

  function automatic logic [2*AW-1:0] exp_contents();
    logic [AW-1:0] h = '0, t = '0;
    if (q.size() >= 1) h = q[0];
    if (q.size() == 2) t = q[1];
    return {h, t};
  endfunction

  function automatic logic [2*AW-1:0] obs_contents();
    logic [AW-1:0] h = '0, t = '0;
    if (q.size() >= 1) h = el1_q;
    if (q.size() == 2) t = el0_q;
    return {h, t};
  endfunction

  task automatic drive(input logic v, input logic y, input logic [AW-1:0] d,
                       input logic [AW-1:0] l);
    v_in = v; yumi_in = y; data_in = d; lookup = l;
    #1;
  endtask

  // Apply the FIFO rules for the current inputs, then move to just after the next edge.
  task automatic advance();
    int n = q.size();
    if (reset_n) begin
      if (yumi_in && n == 0) m_err = 1'b1;
      if (v_in && n == 2 && !yumi_in) m_err = 1'b1;
      if (yumi_in && n > 0) void'(q.pop_front());
      if (v_in && (n < 2 || yumi_in)) q.push_back(data_in);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; q.delete(); m_err = 1'b0;
    v_in = 1'b0; yumi_in = 1'b0;
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; q.delete(); m_err = 1'b0;
    drive(1'b1, 1'b1, A, A);
    checks++;
    if (obs !== exp_outs()) begin
      errors++; $display("FAIL reset_hold outs got %b want %b", obs, exp_outs());
    end
    @(posedge clk); #1;
    checks++;
    if (obs !== exp_outs()) begin
      errors++; $display("FAIL reset_edge outs got %b want %b", obs, exp_outs());
    end
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b0, 1'b0, '0, A);
    checks++;
    if (obs !== exp_outs()) begin
      errors++; $display("FAIL reset_release outs got %b want %b", obs, exp_outs());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_push_snoop();
    step_t s[5];
    s[0] = '{1'b1, 1'b0, A, A};
    s[1] = '{1'b0, 1'b0, B, A};
    s[2] = '{1'b0, 1'b1, B, A};
    s[3] = '{1'b0, 1'b0, B, A};
    s[4] = '{1'b1, 1'b0, B, A};
    foreach (s[i]) begin
      drive(s[i].v, s[i].y, s[i].d, s[i].l);
      checks++;
      if (obs !== exp_outs()) begin
        errors++; $display("FAIL push_snoop step %0d outs got %b want %b", i, obs, exp_outs());
      end
      checks++;
      if (obs_contents() !== exp_contents()) begin
        errors++; $display("FAIL push_snoop step %0d data got %h want %h", i, obs_contents(), exp_contents());
      end
      advance();
    end
    do_reset();
  endtask

  task automatic test_fill_drain();
    step_t s[7];
    s[0] = '{1'b1, 1'b0, A, B};
    s[1] = '{1'b1, 1'b0, B, B};
    s[2] = '{1'b0, 1'b0, C, B};
    s[3] = '{1'b0, 1'b1, C, A};
    s[4] = '{1'b0, 1'b0, C, B};
    s[5] = '{1'b0, 1'b1, C, B};
    s[6] = '{1'b0, 1'b0, C, B};
    foreach (s[i]) begin
      drive(s[i].v, s[i].y, s[i].d, s[i].l);
      checks++;
      if (obs !== exp_outs()) begin
        errors++; $display("FAIL fill_drain step %0d outs got %b want %b", i, obs, exp_outs());
      end
      checks++;
      if (obs_contents() !== exp_contents()) begin
        errors++; $display("FAIL fill_drain step %0d data got %h want %h", i, obs_contents(), exp_contents());
      end
      advance();
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    step_t s[7];
    s[0] = '{1'b1, 1'b0, A, C};
    s[1] = '{1'b1, 1'b0, B, C};
    s[2] = '{1'b1, 1'b1, C, C};
    s[3] = '{1'b0, 1'b0, C, C};
    s[4] = '{1'b0, 1'b1, A, B};
    s[5] = '{1'b0, 1'b1, A, C};
    s[6] = '{1'b0, 1'b0, A, C};
    foreach (s[i]) begin
      drive(s[i].v, s[i].y, s[i].d, s[i].l);
      checks++;
      if (obs !== exp_outs()) begin
        errors++; $display("FAIL back_to_back step %0d outs got %b want %b", i, obs, exp_outs());
      end
      checks++;
      if (obs_contents() !== exp_contents()) begin
        errors++; $display("FAIL back_to_back step %0d data got %h want %h", i, obs_contents(), exp_contents());
      end
      advance();
    end
    do_reset();
  endtask

  task automatic test_protocol_errors();
    step_t s[9];
    s[0] = '{1'b1, 1'b0, A, A};
    s[1] = '{1'b1, 1'b0, B, A};
    s[2] = '{1'b1, 1'b0, C, C};
    s[3] = '{1'b0, 1'b0, C, C};
    s[4] = '{1'b0, 1'b1, C, B};
    s[5] = '{1'b0, 1'b1, C, B};
    s[6] = '{1'b0, 1'b0, C, B};
    s[7] = '{1'b0, 1'b1, C, B};
    s[8] = '{1'b1, 1'b1, A, A};
    foreach (s[i]) begin
      if (i == 7) do_reset();
      drive(s[i].v, s[i].y, s[i].d, s[i].l);
      checks++;
      if (obs !== exp_outs()) begin
        errors++; $display("FAIL protocol_err step %0d outs got %b want %b", i, obs, exp_outs());
      end
      checks++;
      if (obs_contents() !== exp_contents()) begin
        errors++; $display("FAIL protocol_err step %0d data got %h want %h", i, obs_contents(), exp_contents());
      end
      advance();
    end
    drive(1'b0, 1'b0, A, A);
    checks++;
    if (obs !== exp_outs()) begin
      errors++; $display("FAIL protocol_err sticky outs got %b want %b", obs, exp_outs());
    end
    do_reset();
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b0, A, A); advance();
    drive(1'b1, 1'b0, B, A); advance();
    drive(1'b0, 1'b0, C, A);
    checks++;
    if (full !== 1'b1) begin
      errors++; $display("FAIL async_reset precondition full got %b want 1", full);
    end
    #2;
    reset_n = 1'b0; q.delete(); m_err = 1'b0;
    #1;
    checks++;
    if (obs !== exp_outs()) begin
      errors++; $display("FAIL async_reset midcycle outs got %b want %b", obs, exp_outs());
    end
    #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 1'b0, C, A);
    checks++;
    if (obs !== exp_outs()) begin
      errors++; $display("FAIL async_reset after outs got %b want %b", obs, exp_outs());
    end
  endtask

  task automatic test_random();
    logic          v, y;
    logic [AW-1:0] d, l;
    for (int i = 0; i < 400; i++) begin
      y = (q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      v = 1'($urandom_range(0, 1));
      if (q.size() == 2 && !y) v = 1'b0;
      d = {8'($urandom), 32'($urandom)};
      l = {8'($urandom), 32'($urandom)};
      if (q.size() > 0 && $urandom_range(0, 2) != 0) l = q[$urandom_range(0, q.size() - 1)];
      drive(v, y, d, l);
      checks++;
      if (obs !== exp_outs()) begin
        errors++; $display("FAIL random cycle %0d outs got %b want %b", i, obs, exp_outs());
      end
      checks++;
      if (obs_contents() !== exp_contents()) begin
        errors++; $display("FAIL random cycle %0d data got %h want %h", i, obs_contents(), exp_contents());
      end
      advance();
    end
  endtask

  initial begin
    reset_n = 1'b0; v_in = 1'b0; yumi_in = 1'b0; data_in = '0; lookup = '0;
    q.delete(); m_err = 1'b0;
    test_reset();
    test_push_snoop();
    test_fill_drain();
    test_back_to_back();
    test_protocol_errors();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
